// File: rtl/icache_pkg.sv
// Shared types and address helpers for the instruction-cache responder.
package icache_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;

  typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

  // Results are 32 bits wide; callers truncate to IDX_W / TAG_W.
  function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_w);
    return (pc >> 4) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w);
    return pc >> (4 + idx_w);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data store: one combinational read port and one
// line-write port with a per-word enable for refill beats.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - 4 - IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          i_rd_idx,
  output logic                      o_rd_valid,
  output logic [TAG_W-1:0]          o_rd_tag,
  output line_t                     o_rd_line,
  input  logic [IDX_W-1:0]          i_wr_idx,
  input  logic [WORDS_PER_LINE-1:0] i_wr_word_en,
  input  logic [31:0]               i_wr_data,
  input  logic                      i_wr_tag_en,
  input  logic [TAG_W-1:0]          i_wr_tag
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  line_t                r_data [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_tag_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tags and data need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (i_wr_tag_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (i_wr_word_en[w]) begin
        r_data[i_wr_idx][w] <= i_wr_data;
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Cache side of the fetch-queue / I-cache interface: 1-cycle hits, 4-beat
// refills on a miss, and abort handling that never corrupts the array.
module icache_responder
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - 4 - IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  input  logic         cache_rd_en,
  input  logic         cache_abort,
  output logic [127:0] dout,
  output logic         dout_valid,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_rvalid
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_req_pc;
  logic [1:0]  r_beat;
  logic        r_abort;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  line_t       r_dout;
  logic        r_dout_valid;

  logic [IDX_W-1:0]          w_rd_idx, w_req_idx;
  logic [TAG_W-1:0]          w_pc_tag, w_req_tag, w_rd_tag;
  logic                      w_rd_valid, w_hit;
  line_t                     w_rd_line, w_fill_line;
  logic                      w_accept, w_fill_beat, w_fill_last, w_aborted;
  logic [WORDS_PER_LINE-1:0] w_wr_word_en;

  assign w_req_idx = IDX_W'(idx_of(r_req_pc, IDX_W));
  assign w_req_tag = TAG_W'(tag_of(r_req_pc, IDX_W));
  assign w_pc_tag  = TAG_W'(tag_of(pc_in, IDX_W));
  assign w_rd_idx  = (r_state == S_IDLE) ? IDX_W'(idx_of(pc_in, IDX_W)) : w_req_idx;
  assign w_hit     = w_rd_valid && (w_rd_tag == w_pc_tag);
  assign w_aborted = r_abort | cache_abort;

  icache_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_rd_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_line   (w_rd_line),
    .i_wr_idx    (w_req_idx),
    .i_wr_word_en(w_wr_word_en),
    .i_wr_data   (mem_rdata),
    .i_wr_tag_en (w_fill_last),
    .i_wr_tag    (w_req_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fill_beat = 1'b0;
    w_fill_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cache_rd_en) begin
          w_accept = 1'b1;
          if (!w_hit) w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          w_fill_beat = 1'b1;
          if (r_beat == 2'd3) begin
            w_fill_last = 1'b1;
            w_state_nxt = w_aborted ? S_IDLE : S_RESP;
          end
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_word_en = w_fill_beat ? (WORDS_PER_LINE'(1) << r_beat) : '0;

  // Words 0..2 are already in the array by the last beat; word 3 bypasses it.
  always_comb begin
    w_fill_line    = w_rd_line;
    w_fill_line[3] = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_pc     <= '0;
      r_beat       <= '0;
      r_abort      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_accept) begin
        r_req_pc <= pc_in;
        if (w_hit) begin
          r_dout       <= w_rd_line;
          r_dout_valid <= 1'b1;
        end else begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= {pc_in[31:4], 4'b0000};
        end
      end
      if (r_state == S_REFILL && cache_abort) r_abort <= 1'b1;
      if (w_fill_beat) begin
        r_mem_req <= 1'b0;
        r_beat    <= r_beat + 2'd1;
      end
      if (w_fill_last) begin
        r_dout       <= w_fill_line;
        r_dout_valid <= ~w_aborted;
        r_abort      <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid & ~cache_abort;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule
